// File: rtl/serial_tx.sv
// ============================================================================
// serial_tx : one-wire serial transmitter, 8N1 frame, one bit per clock
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_val,
  output logic       in_rdy,
  input  logic [7:0] in_data,
  output logic       tx,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t     r_state;
  logic [7:0] r_shreg;
  logic [2:0] r_cnt;
  logic       w_xfer;

  // in_rdy is itself a register, so the handshake never sees a comb path
  assign w_xfer = in_val & in_rdy;

  // Outputs are registered alongside the state so each one already holds
  // the value that belongs to the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shreg <= 8'h00;
      r_cnt   <= 3'd0;
      tx      <= 1'b1;
      in_rdy  <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_STOP: begin
          if (w_xfer) begin
            r_shreg <= in_data;
            r_state <= S_START;
            tx      <= 1'b0;
            in_rdy  <= 1'b0;
            busy    <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            tx      <= 1'b1;
            in_rdy  <= 1'b1;
            busy    <= 1'b0;
          end
        end
        S_START: begin
          r_cnt   <= 3'd0;
          r_state <= S_DATA;
          tx      <= r_shreg[0];
          in_rdy  <= 1'b0;
          busy    <= 1'b1;
        end
        S_DATA: begin
          r_shreg <= {1'b0, r_shreg[7:1]};
          r_cnt   <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_state <= S_STOP;
            tx      <= 1'b1;
            in_rdy  <= 1'b1;
          end else begin
            r_state <= S_DATA;
            tx      <= r_shreg[1];
            in_rdy  <= 1'b0;
          end
          busy <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          tx      <= 1'b1;
          in_rdy  <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_tx.sv
// ============================================================================
// tb_serial_tx : directed self-checking bench for serial_tx
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_tx;

  logic       clk;
  logic       rst;
  logic       in_val;
  logic       in_rdy;
  logic [7:0] in_data;
  logic       tx;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  serial_tx dut (
    .clk     (clk),
    .rst     (rst),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_data (in_data),
    .tx      (tx),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one edge, then settle so outputs are read away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // hand-written line sequences, index = cycle after transfer minus 1
    logic [9:0] f_a5, f_00, f_ff, f_3c, f_81;
    f_a5 = 10'b11_0100_1010; // 0,1,0,1,0,0,1,0,1,1
    f_00 = 10'b10_0000_0000;
    f_ff = 10'b11_1111_1110;
    f_3c = 10'b10_0111_1000; // 0,0,0,1,1,1,1,0,0,1
    f_81 = 10'b11_0000_0010; // 0,1,0,0,0,0,0,0,1,1

    rst = 1'b1; in_val = 1'b1; in_data = 8'hFF;
    #1;

    // reset with in_val high
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_tx", tx, 1);
      check("rst_rdy", in_rdy, 1);
      check("rst_busy", busy, 0);
    end
    rst = 1'b0; in_val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_tx", tx, 1);
      check("post_rst_busy", busy, 0);
    end

    // single frame 0xA5
    in_val = 1'b1; in_data = 8'hA5;
    tick();
    in_val = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("a5_bit%0d", i), tx, f_a5[i]);
      check($sformatf("a5_busy%0d", i), busy, 1);
      tick();
    end
    check("a5_idle_tx", tx, 1);
    check("a5_idle_busy", busy, 0);
    check("a5_idle_rdy", in_rdy, 1);

    // back-to-back 0x00 then 0xFF
    tick();
    in_val = 1'b1; in_data = 8'h00;
    tick();
    in_data = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("b2b_bit%0d", i), tx, (i < 10) ? f_00[i] : f_ff[i-10]);
      check($sformatf("b2b_busy%0d", i), busy, 1);
      if (i == 9) check("b2b_stop_rdy", in_rdy, 1);
      if (i == 10) in_val = 1'b0;
      tick();
    end
    check("b2b_idle_busy", busy, 0);
    check("b2b_idle_tx", tx, 1);

    // ignored inputs during START/DATA
    tick();
    in_val = 1'b1; in_data = 8'h3C;
    tick();
    in_data = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("ign_bit%0d", i), tx, f_3c[i]);
      if (i < 9) check($sformatf("ign_rdy%0d", i), in_rdy, 0);
      if (i == 8) in_val = 1'b0;
      tick();
    end
    check("ign_idle_busy", busy, 0);

    // reset during data bit 3
    tick();
    in_val = 1'b1; in_data = 8'h00;
    tick();
    in_val = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mid_bit3_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rdy", in_rdy, 1);
    in_val = 1'b1; in_data = 8'h81;
    tick();
    in_val = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("81_bit%0d", i), tx, f_81[i]);
      tick();
    end
    check("81_idle_busy", busy, 0);

    // rst and in_val together
    tick();
    rst = 1'b1; in_val = 1'b1; in_data = 8'h55;
    tick();
    rst = 1'b0; in_val = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("rv_tx%0d", i), tx, 1);
      check($sformatf("rv_busy%0d", i), busy, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
